ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, datapath width; CTRL_WIDTH, 3, ALU control width; REG_ADDR_W, 5, register address width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 in_valid  in  1  decode stage presents an operation.
REQ-005 in_ready  out  1  stage accepts the operation this cycle.
REQ-006 in_alu_control  in  CTRL_WIDTH  ALU operation (000 ADD … 111 SRL).
REQ-007 in_rs1_addr, in_rs2_addr  in  REG_ADDR_W each  source register numbers.
REQ-008 in_rs1_data, in_rs2_data  in  WIDTH each  register-file read data.
REQ-009 in_imm  in  WIDTH  sign-extended immediate; in_use_imm  in  1  selects in_imm as operand B.
REQ-010 in_rd  in  REG_ADDR_W; in_reg_write  in  1  destination and write enable.
REQ-011 in_branch  in  1  conditional branch; in_bne  in  1  0=BEQ, 1=BNE; in_pc  in  WIDTH.
REQ-012 wb_reg_write  in  1; wb_rd  in  REG_ADDR_W; wb_data  in  WIDTH  writeback bypass source.
REQ-013 flush  in  1  discard the incoming and the held operation.
REQ-014 out_valid  out  1; out_ready  in  1  downstream (MEM) handshake.
REQ-015 out_result  out  WIDTH; out_rd  out  REG_ADDR_W; out_reg_write  out  1.
REQ-016 out_carry, out_overflow, out_zero  out  1 each  registered ALU flags.
REQ-017 br_taken  out  1; br_target  out  WIDTH  branch resolution, registered with the result.

Function
REQ-018 Latency SHALL be one cycle: an operation accepted at edge N appears on out_* after edge N.
REQ-019 in_ready SHALL equal (!out_valid || out_ready); transfer in occurs when in_valid && in_ready.
REQ-020 When out_valid && !out_ready, all out_* SHALL hold stable.
REQ-021 Operand A forwarding: if out_valid && out_reg_write && out_rd!=0 && out_rd==in_rs1_addr, use out_result; else if wb_reg_write && wb_rd!=0 && wb_rd==in_rs1_addr, use wb_data; else in_rs1_data.
REQ-022 Operand B forwarding SHALL follow REQ-021 on in_rs2_addr, then in_use_imm selects in_imm over the forwarded value.
REQ-023 The EX-result bypass SHALL have priority over the WB bypass; register 0 is never forwarded.
REQ-024 Arithmetic SHALL match the ALU: SUB = A + ~B + 1; carry, overflow, zero per ALU definitions; SLT unsigned; shifts by full B value, results truncated to WIDTH.
REQ-025 Branch: br_taken = in_branch && (in_bne ? !zero : zero) of the ALU result; br_target = in_pc + in_imm modulo 2^WIDTH.
REQ-026 A non-branch operation SHALL register br_taken=0.
REQ-027 Acceptance with out_ready high and a held result SHALL replace the result in the same edge (full throughput, no bubble).
REQ-028 flush SHALL clear out_valid at the next edge regardless of in_valid/out_ready; no operation is accepted that cycle.
REQ-029 Cycles with no acceptance and out_ready high SHALL clear out_valid.

Reset
REQ-030 With rst_n low at an edge, out_valid, out_result, out_rd, out_reg_write, flags, br_taken, br_target SHALL all become 0; in_ready is 1 the cycle after.
REQ-031 Reset SHALL override flush and any handshake mid-operation; held data is lost.

Structure
REQ-032 ALU opcode constants (ADD…SRL) and WIDTH defaults SHALL live in a shared package used by ALU and ex_stage.
REQ-033 ex_stage SHALL instantiate the existing ALU as its single sub-module; forwarding, branch logic and output register are local.

Verification
REQ-034 ADD rs1=5, rs2=7, no hazard -> next cycle out_valid=1, out_result=12, out_zero=0.
REQ-035 Back-to-back: ADD x1=3+4 then SUB x2=x1-2 -> second out_result=5 via EX bypass; with wb_rd=1, wb_data=99 simultaneously, EX bypass still wins.
REQ-036 out_ready low 3 cycles with in_valid high -> in_ready=0, out_* constant, then one transfer per cycle after release.
REQ-037 BEQ rs1=rs2=0x10, pc=0x100, imm=0x20 -> br_taken=1, br_target=0x120; BNE same operands -> br_taken=0.
REQ-038 SUB 0x80000000-1 -> out_result=0x7FFFFFFF, out_overflow=1; flush asserted same cycle -> out_valid=0 next cycle.
REQ-039 rst_n low while out_valid=1 and out_ready=0 -> all outputs 0 next cycle, in_ready=1.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared ALU opcodes, datapath defaults and branch-decision helper for the execute stage.
// Used by both ex_stage and its ALU so opcode encodings cannot drift apart.
package ex_stage_pkg;

  localparam int DATA_W          = 32;
  localparam int ALU_CTRL_W      = 3;
  localparam int REG_ADDR_W_DFLT = 5;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  // BEQ takes the branch on a zero difference, BNE on a non-zero one.
  function automatic logic branch_taken(input logic branch, input logic bne, input logic zero);
    return branch && (bne ? !zero : zero);
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU: ADD/SUB/AND/OR/XOR/SLT(unsigned)/SLL/SRL with carry, overflow, zero.
// Zero latency, no handshake; carry/overflow are only meaningful for ADD and SUB.
module ex_stage_alu
  import ex_stage_pkg::*;
#(
  parameter int WIDTH      = DATA_W,
  parameter int CTRL_WIDTH = ALU_CTRL_W
) (
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [CTRL_WIDTH-1:0] op,
  output logic [WIDTH-1:0]      result,
  output logic                  carry,
  output logic                  overflow,
  output logic                  zero
);

  alu_op_e          op_e;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;

  assign op_e     = alu_op_e'(op);
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  // Subtraction as A + ~B + 1, so carry out means "no borrow".
  assign diff_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op_e)
      ALU_ADD: begin
        result   = sum_ext[WIDTH-1:0];
        carry    = sum_ext[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result   = diff_ext[WIDTH-1:0];
        carry    = diff_ext[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL: result = a << b;
      ALU_SRL: result = a >> b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand bypass (EX result over WB), ALU, branch resolution, one output register.
// One-cycle latency; in_ready = !out_valid || out_ready, outputs hold while stalled; flush drops both ops.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int WIDTH      = DATA_W,
  parameter int CTRL_WIDTH = ALU_CTRL_W,
  parameter int REG_ADDR_W = REG_ADDR_W_DFLT
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_alu_control,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [WIDTH-1:0]      in_rs1_data,
  input  logic [WIDTH-1:0]      in_rs2_data,
  input  logic [WIDTH-1:0]      in_imm,
  input  logic                  in_use_imm,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_branch,
  input  logic                  in_bne,
  input  logic [WIDTH-1:0]      in_pc,

  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [WIDTH-1:0]      wb_data,

  input  logic                  flush,

  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_carry,
  output logic                  out_overflow,
  output logic                  out_zero,
  output logic                  br_taken,
  output logic [WIDTH-1:0]      br_target
);

  function automatic logic [WIDTH-1:0] bypass(
    input logic [REG_ADDR_W-1:0] src,
    input logic [WIDTH-1:0]      rf_data,
    input logic                  ex_en,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic [WIDTH-1:0]      ex_data,
    input logic                  wb_en,
    input logic [REG_ADDR_W-1:0] wb_addr,
    input logic [WIDTH-1:0]      wb_val
  );
    // The younger EX result wins; x0 is hardwired so it is never bypassed.
    if (ex_en && (ex_rd != '0) && (ex_rd == src)) begin
      return ex_data;
    end else if (wb_en && (wb_addr != '0) && (wb_addr == src)) begin
      return wb_val;
    end
    return rf_data;
  endfunction

  logic             ex_fwd_en;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] rs2_fwd;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_overflow;
  logic             alu_zero;
  logic             accept;
  logic             taken_nxt;
  logic [WIDTH-1:0] target_nxt;

  assign ex_fwd_en = out_valid && out_reg_write;

  assign op_a    = bypass(in_rs1_addr, in_rs1_data, ex_fwd_en, out_rd, out_result,
                          wb_reg_write, wb_rd, wb_data);
  assign rs2_fwd = bypass(in_rs2_addr, in_rs2_data, ex_fwd_en, out_rd, out_result,
                          wb_reg_write, wb_rd, wb_data);
  assign op_b    = in_use_imm ? in_imm : rs2_fwd;

  ex_stage_alu #(
    .WIDTH      (WIDTH),
    .CTRL_WIDTH (CTRL_WIDTH)
  ) u_alu (
    .a        (op_a),
    .b        (op_b),
    .op       (in_alu_control),
    .result   (alu_result),
    .carry    (alu_carry),
    .overflow (alu_overflow),
    .zero     (alu_zero)
  );

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready && !flush;
  assign taken_nxt  = branch_taken(in_branch, in_bne, alu_zero);
  assign target_nxt = in_pc + in_imm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_carry     <= 1'b0;
      out_overflow  <= 1'b0;
      out_zero      <= 1'b0;
      br_taken      <= 1'b0;
      br_target     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      // Loading over a result being drained keeps full throughput with no bubble.
      out_valid     <= 1'b1;
      out_result    <= alu_result;
      out_rd        <= in_rd;
      out_reg_write <= in_reg_write;
      out_carry     <= alu_carry;
      out_overflow  <= alu_overflow;
      out_zero      <= alu_zero;
      br_taken      <= taken_nxt;
      br_target     <= target_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboarded bench for ex_stage: directed vectors push expected results, a monitor pops on each transfer.
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam int W  = 32;
  localparam int CW = 3;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [CW-1:0] in_alu_control;
  logic [RW-1:0] in_rs1_addr, in_rs2_addr, in_rd, wb_rd, out_rd;
  logic [W-1:0]  in_rs1_data, in_rs2_data, in_imm, in_pc, wb_data, out_result, br_target;
  logic          in_use_imm, in_reg_write, in_branch, in_bne, wb_reg_write, flush;
  logic          out_valid, out_ready, out_reg_write, out_carry, out_overflow, out_zero, br_taken;

  typedef struct {
    logic [2:0]    ctrl;
    logic [RW-1:0] rs1a;
    logic [W-1:0]  rs1d;
    logic [RW-1:0] rs2a;
    logic [W-1:0]  rs2d;
    logic          ui;
    logic [W-1:0]  imm;
    logic [RW-1:0] rd;
    logic          rw, br, bne;
    logic [W-1:0]  pc;
  } op_t;

  typedef struct {
    logic [W-1:0]  result;
    logic [RW-1:0] rd;
    logic          rw, c, v, z, bt;
    logic [W-1:0]  tgt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   out_n  = 0;

  always #5 clk = ~clk;

  ex_stage #(.WIDTH(W), .CTRL_WIDTH(CW), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_control(in_alu_control),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_branch(in_branch), .in_bne(in_bne), .in_pc(in_pc),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_carry(out_carry), .out_overflow(out_overflow), .out_zero(out_zero),
    .br_taken(br_taken), .br_target(br_target)
  );

  function automatic op_t mk(input logic [2:0] ctrl, input logic [RW-1:0] rs1a, input logic [W-1:0] rs1d,
                             input logic [RW-1:0] rs2a, input logic [W-1:0] rs2d, input logic ui,
                             input logic [W-1:0] imm, input logic [RW-1:0] rd, input logic rw,
                             input logic br, input logic bne, input logic [W-1:0] pc);
    op_t o;
    o.ctrl = ctrl; o.rs1a = rs1a; o.rs1d = rs1d; o.rs2a = rs2a; o.rs2d = rs2d; o.ui = ui;
    o.imm = imm; o.rd = rd; o.rw = rw; o.br = br; o.bne = bne; o.pc = pc;
    return o;
  endfunction

  function automatic exp_t ex(input logic [W-1:0] result, input logic [RW-1:0] rd, input logic rw,
                              input logic c, input logic v, input logic z, input logic bt,
                              input logic [W-1:0] tgt);
    exp_t e;
    e.result = result; e.rd = rd; e.rw = rw; e.c = c; e.v = v; e.z = z; e.bt = bt; e.tgt = tgt;
    return e;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input op_t o);
    in_alu_control = o.ctrl;
    in_rs1_addr    = o.rs1a;  in_rs1_data = o.rs1d;
    in_rs2_addr    = o.rs2a;  in_rs2_data = o.rs2d;
    in_use_imm     = o.ui;    in_imm      = o.imm;
    in_rd          = o.rd;    in_reg_write = o.rw;
    in_branch      = o.br;    in_bne      = o.bne;
    in_pc          = o.pc;
  endtask

  // Present an op, wait (bounded) until it is accepted, then record its expected result.
  task automatic send(input op_t o, input exp_t e);
    int n;
    drive(o);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    wb_reg_write = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: every transfer to MEM must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got result 0x%0h, required no transfer", out_result);
        end else begin
          e = sb.pop_front();
          check($sformatf("out%0d_result", out_n), out_result, e.result);
          check($sformatf("out%0d_rd", out_n), W'(out_rd), W'(e.rd));
          check($sformatf("out%0d_reg_write", out_n), W'(out_reg_write), W'(e.rw));
          check($sformatf("out%0d_carry", out_n), W'(out_carry), W'(e.c));
          check($sformatf("out%0d_overflow", out_n), W'(out_overflow), W'(e.v));
          check($sformatf("out%0d_zero", out_n), W'(out_zero), W'(e.z));
          check($sformatf("out%0d_br_taken", out_n), W'(br_taken), W'(e.bt));
          check($sformatf("out%0d_br_target", out_n), br_target, e.tgt);
        end
        out_n++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    drive(mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_out_result", out_result, 0);
    check("rst_br_target", br_target, 0);
    check("rst_in_ready", W'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic ADD, then EX bypass beating a simultaneous WB bypass of the same register.
    send(mk(ALU_ADD, 10, 5, 11, 7, 0, 0, 3, 1, 0, 0, 0), ex(12, 3, 1, 0, 0, 0, 0, 0));
    send(mk(ALU_ADD, 12, 3, 13, 4, 0, 0, 1, 1, 0, 0, 0), ex(7, 1, 1, 0, 0, 0, 0, 0));
    wb_reg_write = 1'b1; wb_rd = 5'd1; wb_data = 32'd99;
    send(mk(ALU_SUB, 1, 0, 0, 0, 1, 2, 2, 1, 0, 0, 0), ex(5, 2, 1, 1, 0, 0, 0, 2));
    idle();
    @(negedge clk);
    check("drain_out_valid", W'(out_valid), 0);
    @(posedge clk); #1;

    // WB bypass alone, then x0 must never be bypassed from WB or EX.
    wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 32'd50;
    send(mk(ALU_ADD, 3, 1, 14, 8, 0, 0, 4, 1, 0, 0, 0), ex(58, 4, 1, 0, 0, 0, 0, 0));
    wb_rd = 5'd0; wb_data = 32'd77;
    send(mk(ALU_ADD, 0, 0, 15, 1, 0, 0, 0, 1, 0, 0, 0), ex(1, 0, 1, 0, 0, 0, 0, 0));
    send(mk(ALU_ADD, 0, 0, 16, 5, 0, 0, 5, 1, 0, 0, 0), ex(5, 5, 1, 0, 0, 0, 0, 0));
    wb_reg_write = 1'b0;

    // ALU corner cases and flags.
    send(mk(ALU_ADD, 20, 32'hFFFF_FFFF, 21, 1, 0, 0, 6, 1, 0, 0, 0), ex(0, 6, 1, 1, 0, 1, 0, 0));
    send(mk(ALU_ADD, 22, 32'h7FFF_FFFF, 23, 1, 0, 0, 7, 1, 0, 0, 0), ex(32'h8000_0000, 7, 1, 0, 1, 0, 0, 0));
    send(mk(ALU_XOR, 24, 32'hF0F0, 0, 0, 1, 32'hFF, 8, 0, 0, 0, 32'h10), ex(32'hF00F, 8, 0, 0, 0, 0, 0, 32'h10F));
    send(mk(ALU_SLT, 25, 32'hFFFF_FFFF, 26, 1, 0, 0, 9, 1, 0, 0, 0), ex(0, 9, 1, 0, 0, 1, 0, 0));
    send(mk(ALU_SLL, 27, 1, 28, 33, 0, 0, 10, 1, 0, 0, 0), ex(0, 10, 1, 0, 0, 1, 0, 0));
    send(mk(ALU_AND, 29, 32'hFF00_FF00, 30, 32'h0FF0_0FF0, 0, 0, 11, 1, 0, 0, 0), ex(32'h0F00_0F00, 11, 1, 0, 0, 0, 0, 0));
    send(mk(ALU_SRL, 31, 32'h8000_0000, 17, 4, 0, 0, 12, 1, 0, 0, 0), ex(32'h0800_0000, 12, 1, 0, 0, 0, 0, 0));

    // Branches: BEQ taken, BNE not taken on equal operands, BNE taken on unequal.
    send(mk(ALU_SUB, 18, 32'h10, 19, 32'h10, 0, 32'h20, 0, 0, 1, 0, 32'h100), ex(0, 0, 0, 1, 0, 1, 1, 32'h120));
    send(mk(ALU_SUB, 18, 32'h10, 19, 32'h10, 0, 32'h20, 0, 0, 1, 1, 32'h100), ex(0, 0, 0, 1, 0, 1, 0, 32'h120));
    send(mk(ALU_SUB, 18, 5, 19, 3, 0, 8, 0, 0, 1, 1, 32'h200), ex(2, 0, 0, 1, 0, 0, 1, 32'h208));
    idle();

    // Backpressure: result must hold and in_ready stay low while out_ready is low.
    out_ready = 1'b0;
    send(mk(ALU_OR, 20, 32'hA0, 21, 32'h0B, 0, 0, 13, 1, 0, 0, 0), ex(32'hAB, 13, 1, 0, 0, 0, 0, 0));
    drive(mk(ALU_ADD, 22, 1, 23, 1, 0, 0, 14, 1, 0, 0, 0));
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_in_ready", i), W'(in_ready), 0);
      check($sformatf("stall%0d_out_valid", i), W'(out_valid), 1);
      check($sformatf("stall%0d_out_result", i), out_result, 32'hAB);
      check($sformatf("stall%0d_out_rd", i), W'(out_rd), 13);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(mk(ALU_ADD, 22, 1, 23, 1, 0, 0, 14, 1, 0, 0, 0), ex(2, 14, 1, 0, 0, 0, 0, 0));
    send(mk(ALU_SUB, 24, 10, 25, 3, 0, 0, 15, 1, 0, 0, 0), ex(7, 15, 1, 1, 0, 0, 0, 0));
    idle();

    // Signed overflow on SUB, then a flush that must drop both the held and the incoming op.
    send(mk(ALU_SUB, 26, 32'h8000_0000, 27, 1, 0, 0, 16, 1, 0, 0, 0), ex(32'h7FFF_FFFF, 16, 1, 1, 1, 0, 0, 0));
    drive(mk(ALU_ADD, 28, 1, 29, 1, 0, 0, 17, 1, 0, 0, 0));
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", W'(out_valid), 0);
    @(posedge clk); #1;

    // Reset while a branch result is held under backpressure.
    out_ready = 1'b0;
    drive(mk(ALU_SUB, 20, 3, 21, 3, 0, 4, 18, 1, 1, 0, 32'h40));
    in_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("held_out_valid", W'(out_valid), 1);
    check("held_br_taken", W'(br_taken), 1);
    check("held_br_target", br_target, 32'h44);
    @(posedge clk); #1;
    rst_n = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst2_out_valid", W'(out_valid), 0);
    check("rst2_out_result", out_result, 0);
    check("rst2_out_rd", W'(out_rd), 0);
    check("rst2_out_reg_write", W'(out_reg_write), 0);
    check("rst2_flags", W'({out_carry, out_overflow, out_zero}), 0);
    check("rst2_br_taken", W'(br_taken), 0);
    check("rst2_br_target", br_target, 0);
    check("rst2_in_ready", W'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_empty", W'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
